blit_engine: RTL and testbench

Graphics command engine directly downstream of the EPP register interface. It consumes the start strobes, rectangle coordinates and DMA bytes that interface produces. It executes fill, blit (rectangle copy) and byte-wide DMA against a 1-bit-per-pixel framebuffer RAM, and returns `status` plus DMA read data.

---
 rtl/blit_engine.sv | 255 +++++++++++++++++++++++++
 tb/tb_blit_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_engine.sv
// blit_engine: fill / rectangle-copy / byte-DMA engine for a 1-bit-per-pixel
// framebuffer with a single read/write port.
// Optional feature: define BLIT_CLIP_EN to skip pixels outside the
// framebuffer. Skipped source pixels read as 0.
// Without it the linear address is simply truncated to 16 bits.
module blit_engine #(
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  X1,
    input  logic [7:0]  Y1,
    input  logic [8:0]  X2,
    input  logic [7:0]  Y2,
    input  logic [8:0]  op_width,
    input  logic [7:0]  op_height,
    input  logic        start_blit,
    input  logic        start_fill,
    input  logic        fill_value,
    input  logic        start_write_ram,
    input  logic [7:0]  write_ram_byte,
    input  logic        start_read_ram,
    output logic        status,
    output logic        ram_byte_ready,
    output logic [7:0]  ram_byte,
    output logic [15:0] fb_addr,
    output logic        fb_we,
    output logic        fb_wdata,
    input  logic        fb_rdata
);

    localparam logic [31:0] FB_W_U   = 32'(FB_WIDTH);
    localparam logic [31:0] FB_PIX_U = 32'(FB_WIDTH * FB_HEIGHT);
`ifdef BLIT_CLIP_EN
    localparam logic [31:0] FB_H_U   = 32'(FB_HEIGHT);
`endif

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FILL        = 3'd1,
        BLIT_RD     = 3'd2,
        BLIT_WR     = 3'd3,
        DMA_WR      = 3'd4,
        DMA_RD      = 3'd5,
        DMA_RD_DONE = 3'd6
    } state_t;

    state_t      state_r;
    logic [8:0]  x1_r, x2_r, w_r, i_r;
    logic [7:0]  y1_r, y2_r, h_r, j_r;
    logic        fill_val_r, done_r, src_ok_r;
    logic [7:0]  wbyte_r, shift_r;
    logic [3:0]  cnt_r;
    logic [15:0] ptr_r;
    logic        status_r, ready_r, fb_we_r, fb_wdata_r;
    logic [7:0]  ram_byte_r;
    logic [15:0] fb_addr_r;

    logic [9:0]  src_x_s, dst_x_s;
    logic [8:0]  src_y_s, dst_y_s;
    logic [15:0] src_addr_s, dst_addr_s, dma_addr_s, ptr_next_s;
    logic [16:0] ptr_sum_s;
    logic        src_in_s, dst_in_s, last_s;
    logic [8:0]  i_next_s;
    logic [7:0]  j_next_s;

    // Linear pixel address y*FB_WIDTH + x, truncated to the 16-bit bus.
    function automatic logic [15:0] lin_addr(input logic [9:0] x, input logic [8:0] y);
        return 16'(({23'd0, y} * FB_W_U) + {22'd0, x});
    endfunction

    // Rectangle coordinates, traversal step, DMA pointer arithmetic and clipping.
    always_comb begin
        src_x_s    = {1'b0, x1_r} + {1'b0, i_r};
        src_y_s    = {1'b0, y1_r} + {1'b0, j_r};
        dst_x_s    = {1'b0, x2_r} + {1'b0, i_r};
        dst_y_s    = {1'b0, y2_r} + {1'b0, j_r};
        src_addr_s = lin_addr(src_x_s, src_y_s);
        dst_addr_s = lin_addr(dst_x_s, dst_y_s);
        last_s     = (i_r == w_r - 9'd1) && (j_r == h_r - 8'd1);
        if (i_r == w_r - 9'd1) begin
            i_next_s = 9'd0;
            j_next_s = j_r + 8'd1;
        end else begin
            i_next_s = i_r + 9'd1;
            j_next_s = j_r;
        end
        dma_addr_s = ptr_r + {13'd0, cnt_r[2:0]};
        ptr_sum_s  = {1'b0, ptr_r} + 17'd8;
        if ({15'd0, ptr_sum_s} >= FB_PIX_U) begin
            ptr_next_s = 16'd0;
        end else begin
            ptr_next_s = ptr_sum_s[15:0];
        end
`ifdef BLIT_CLIP_EN
        src_in_s = ({22'd0, src_x_s} < FB_W_U) && ({23'd0, src_y_s} < FB_H_U);
        dst_in_s = ({22'd0, dst_x_s} < FB_W_U) && ({23'd0, dst_y_s} < FB_H_U);
`else
        src_in_s = 1'b1;
        dst_in_s = 1'b1;
`endif
    end

    // Command FSM: accepts strobes in IDLE, sequences framebuffer accesses, drives all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            x1_r       <= 9'd0;
            y1_r       <= 8'd0;
            x2_r       <= 9'd0;
            y2_r       <= 8'd0;
            w_r        <= 9'd0;
            h_r        <= 8'd0;
            i_r        <= 9'd0;
            j_r        <= 8'd0;
            fill_val_r <= 1'b0;
            wbyte_r    <= 8'd0;
            done_r     <= 1'b0;
            src_ok_r   <= 1'b0;
            cnt_r      <= 4'd0;
            ptr_r      <= 16'd0;
            shift_r    <= 8'd0;
            status_r   <= 1'b0;
            ready_r    <= 1'b0;
            ram_byte_r <= 8'd0;
            fb_addr_r  <= 16'd0;
            fb_we_r    <= 1'b0;
            fb_wdata_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    fb_we_r <= 1'b0;
                    ready_r <= 1'b0;
                    i_r     <= 9'd0;
                    j_r     <= 8'd0;
                    cnt_r   <= 4'd0;
                    if (start_fill || start_blit || start_write_ram || start_read_ram) begin
                        x1_r       <= X1;
                        y1_r       <= Y1;
                        x2_r       <= X2;
                        y2_r       <= Y2;
                        w_r        <= op_width;
                        h_r        <= op_height;
                        fill_val_r <= fill_value;
                        wbyte_r    <= write_ram_byte;
                        done_r     <= (op_width == 9'd0) || (op_height == 8'd0);
                        status_r   <= 1'b1;
                    end else begin
                        status_r <= 1'b0;
                    end
                    if (start_fill) begin
                        state_r <= FILL;
                    end else if (start_blit) begin
                        state_r <= BLIT_RD;
                    end else if (start_write_ram) begin
                        state_r <= DMA_WR;
                    end else if (start_read_ram) begin
                        state_r <= DMA_RD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FILL: begin
                    if (done_r) begin
                        fb_we_r  <= 1'b0;
                        status_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        fb_addr_r  <= src_addr_s;
                        fb_wdata_r <= fill_val_r;
                        fb_we_r    <= src_in_s;
                        i_r        <= i_next_s;
                        j_r        <= j_next_s;
                        done_r     <= last_s;
                    end
                end
                BLIT_RD: begin
                    fb_we_r <= 1'b0;
                    if (done_r) begin
                        status_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        fb_addr_r <= src_addr_s;
                        src_ok_r  <= src_in_s;
                        state_r   <= BLIT_WR;
                    end
                end
                BLIT_WR: begin
                    fb_addr_r  <= dst_addr_s;
                    fb_wdata_r <= src_ok_r & fb_rdata;
                    fb_we_r    <= dst_in_s;
                    i_r        <= i_next_s;
                    j_r        <= j_next_s;
                    done_r     <= last_s;
                    state_r    <= BLIT_RD;
                end
                DMA_WR: begin
                    if (cnt_r == 4'd8) begin
                        fb_we_r  <= 1'b0;
                        status_r <= 1'b0;
                        ptr_r    <= ptr_next_s;
                        state_r  <= IDLE;
                    end else begin
                        fb_addr_r  <= dma_addr_s;
                        fb_wdata_r <= wbyte_r[3'd7 - cnt_r[2:0]];
                        fb_we_r    <= 1'b1;
                        cnt_r      <= cnt_r + 4'd1;
                    end
                end
                DMA_RD: begin
                    fb_we_r <= 1'b0;
                    cnt_r   <= cnt_r + 4'd1;
                    if (cnt_r < 4'd8) begin
                        fb_addr_r <= dma_addr_s;
                    end else begin
                        fb_addr_r <= fb_addr_r;
                    end
                    if ((cnt_r >= 4'd1) && (cnt_r <= 4'd8)) begin
                        shift_r <= {shift_r[6:0], fb_rdata};
                    end else begin
                        shift_r <= shift_r;
                    end
                    if (cnt_r == 4'd9) begin
                        ram_byte_r <= shift_r;
                        ready_r    <= 1'b1;
                        ptr_r      <= ptr_next_s;
                        state_r    <= DMA_RD_DONE;
                    end else begin
                        state_r <= DMA_RD;
                    end
                end
                DMA_RD_DONE: begin
                    ready_r  <= 1'b0;
                    status_r <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    fb_we_r  <= 1'b0;
                    ready_r  <= 1'b0;
                    status_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign status         = status_r;
    assign ram_byte_ready = ready_r;
    assign ram_byte       = ram_byte_r;
    assign fb_addr        = fb_addr_r;
    assign fb_we          = fb_we_r;
    assign fb_wdata       = fb_wdata_r;

endmodule

// File: tb/tb_blit_engine.sv
// Self-checking bench for blit_engine: behavioural framebuffer model,
// randomized fill/blit/DMA commands, timing and boundary checks.
module tb_blit_engine;

    localparam int FBW  = 320;
    localparam int FBH  = 40;
    localparam int NPIX = FBW * FBH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  X1, X2, op_width;
    logic [7:0]  Y1, Y2, op_height;
    logic        start_blit, start_fill, fill_value, start_write_ram, start_read_ram;
    logic [7:0]  write_ram_byte;
    logic        status, ram_byte_ready, fb_we, fb_wdata, fb_rdata;
    logic [7:0]  ram_byte;
    logic [15:0] fb_addr;

    logic        mem     [0:65535];
    logic        ref_mem [0:65535];
    int unsigned wr_q[$];
    int unsigned exp_q[$];
    int          model_ptr = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    blit_engine #(.FB_WIDTH(FBW), .FB_HEIGHT(FBH)) dut (
        .clk(clk), .rst_n(rst_n),
        .X1(X1), .Y1(Y1), .X2(X2), .Y2(Y2),
        .op_width(op_width), .op_height(op_height),
        .start_blit(start_blit), .start_fill(start_fill), .fill_value(fill_value),
        .start_write_ram(start_write_ram), .write_ram_byte(write_ram_byte),
        .start_read_ram(start_read_ram),
        .status(status), .ram_byte_ready(ram_byte_ready), .ram_byte(ram_byte),
        .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata)
    );

    // framebuffer RAM: read data available for sampling at the next edge
    assign fb_rdata = mem[fb_addr];

    always @(posedge clk) begin
        if (fb_we === 1'b1) begin
            mem[fb_addr] <= fb_wdata;
            wr_q.push_back(32'(fb_addr));
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_in(input int x, input int y);
        bit in_b;
        in_b = (x < FBW) && (y < FBH);
`ifdef BLIT_CLIP_EN
        return in_b;
`else
        return in_b | 1'b1;
`endif
    endfunction

    function automatic int model_addr(input int x, input int y);
        return (y * FBW + x) & 32'hFFFF;
    endfunction

    task automatic model_fill(input int x1, input int y1, input int w, input int h, input logic fv);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                if (model_in(x1 + i, y1 + j)) begin
                    ref_mem[model_addr(x1 + i, y1 + j)] = fv;
                    exp_q.push_back(model_addr(x1 + i, y1 + j));
                end
    endtask

    task automatic model_blit(input int x1, input int y1, input int x2, input int y2, input int w, input int h);
        logic v;
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++) begin
                v = model_in(x1 + i, y1 + j) ? ref_mem[model_addr(x1 + i, y1 + j)] : 1'b0;
                if (model_in(x2 + i, y2 + j)) begin
                    ref_mem[model_addr(x2 + i, y2 + j)] = v;
                    exp_q.push_back(model_addr(x2 + i, y2 + j));
                end
            end
    endtask

    task automatic model_step_ptr();
        model_ptr = (model_ptr + 8 >= NPIX) ? 0 : model_ptr + 8;
    endtask

    task automatic model_dmaw(input logic [7:0] b);
        for (int k = 0; k < 8; k++) begin
            ref_mem[(model_ptr + k) & 32'hFFFF] = b[7 - k];
            exp_q.push_back((model_ptr + k) & 32'hFFFF);
        end
        model_step_ptr();
    endtask

    task automatic model_dmar(output logic [7:0] r);
        for (int k = 0; k < 8; k++) r[7 - k] = ref_mem[(model_ptr + k) & 32'hFFFF];
        model_step_ptr();
    endtask

    task automatic mem_check(input string tag);
        int diffs = 0;
        for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) diffs++;
        check_eq(tag, diffs, 0);
    endtask

    // kind: 0 fill, 1 blit, 2 DMA write, 3 DMA read
    task automatic run_op(input int kind, input int x1, input int y1, input int x2, input int y2,
                          input int w, input int h, input logic fv, input logic [7:0] b,
                          input bit dual, input bit poke);
        int n = 0, ready_at = 0, ready_cnt = 0, exp_busy = 0, mism = 0;
        logic [7:0] exp_byte = 8'd0;
        wr_q.delete();
        exp_q.delete();
        X1 = 9'(x1); Y1 = 8'(y1); X2 = 9'(x2); Y2 = 8'(y2);
        op_width = 9'(w); op_height = 8'(h); fill_value = fv; write_ram_byte = b;
        start_fill = (kind == 0);
        start_blit = (kind == 1) || dual;
        start_write_ram = (kind == 2);
        start_read_ram = (kind == 3);
        @(negedge clk);
        start_fill = 1'b0; start_blit = 1'b0; start_write_ram = 1'b0; start_read_ram = 1'b0;
        X1 = 9'($urandom); Y1 = 8'($urandom); X2 = 9'($urandom); Y2 = 8'($urandom);
        op_width = 9'($urandom); op_height = 8'($urandom);
        fill_value = ~fv; write_ram_byte = ~b;
        while (status === 1'b1 && n < 5000) begin
            n++;
            if (ram_byte_ready === 1'b1) begin
                ready_cnt++;
                ready_at = n;
            end
            start_blit = poke && (n == 2);
            @(negedge clk);
        end
        start_blit = 1'b0;
        case (kind)
            0: begin model_fill(x1, y1, w, h, fv); exp_busy = w * h + 1; end
            1: begin model_blit(x1, y1, x2, y2, w, h); exp_busy = 2 * w * h + 1; end
            2: begin model_dmaw(b); exp_busy = 9; end
            default: begin model_dmar(exp_byte); exp_busy = 11; end
        endcase
        check_eq("busy_cycles", n, exp_busy);
        if (wr_q.size() != exp_q.size()) mism = 100000 + wr_q.size();
        else foreach (exp_q[k]) if (wr_q[k] != exp_q[k]) mism++;
        check_eq("write_sequence", mism, 0);
        if (kind == 3) begin
            check_eq("ready_cycle", ready_at, 11);
            check_eq("ready_pulses", ready_cnt, 1);
            check_eq("ram_byte", ram_byte, exp_byte);
        end
    endtask

    initial begin
        int kind, x, y, w, h;
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 1'b0;
            ref_mem[a] = 1'b0;
        end
        {X1, Y1, X2, Y2, op_width, op_height} = '0;
        {start_blit, start_fill, fill_value, start_write_ram, start_read_ram} = '0;
        write_ram_byte = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_status", status, 0);
        check_eq("rst_ready", ram_byte_ready, 0);
        check_eq("rst_ram_byte", ram_byte, 0);
        check_eq("rst_fb_we", fb_we, 0);
        check_eq("rst_fb_addr", fb_addr, 0);
        check_eq("rst_fb_wdata", fb_wdata, 0);

        // directed: fill, blit, DMA write/read
        run_op(0, 10, 5, 0, 0, 3, 2, 1'b1, 8'd0, 1'b0, 1'b0);
        check_eq("fill_first_addr", (wr_q.size() > 0) ? wr_q[0] : 32'hFFFFFFFF, 1610);
        mem_check("mem_fill");
        run_op(2, 0, 0, 0, 0, 0, 0, 1'b0, 8'h80, 1'b0, 1'b0);
        run_op(1, 0, 0, 4, 0, 2, 1, 1'b0, 8'd0, 1'b0, 1'b0);
        check_eq("blit_px4", mem[4], 1);
        check_eq("blit_px5", mem[5], 0);
        run_op(2, 0, 0, 0, 0, 0, 0, 1'b0, 8'hA5, 1'b0, 1'b0);
        run_op(3, 0, 0, 0, 0, 0, 0, 1'b0, 8'd0, 1'b0, 1'b0);
        run_op(0, 0, 0, 0, 0, 0, 4, 1'b1, 8'd0, 1'b0, 1'b0);
        run_op(1, 0, 0, 9, 9, 5, 0, 1'b0, 8'd0, 1'b0, 1'b0);
        // priority and ignoring strobes while busy
        run_op(0, 40, 2, 0, 0, 5, 2, 1'b1, 8'd0, 1'b1, 1'b0);
        run_op(0, 60, 2, 0, 0, 4, 3, 1'b1, 8'd0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        check_eq("no_queue", status, 0);
        mem_check("mem_directed");

        // randomized commands against the model
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 3);
            x = $urandom_range(0, 300);
            y = $urandom_range(0, 30);
            w = $urandom_range(0, 12);
            h = $urandom_range(0, 6);
            run_op(kind, x, y, $urandom_range(0, 300), $urandom_range(0, 30), w, h,
                   1'($urandom), 8'($urandom), 1'b0, 1'b0);
            mem_check("mem_random");
        end

        // make the next DMA byte all ones so ram_byte is nonzero before reset
        run_op(0, model_ptr % FBW, model_ptr / FBW, 0, 0, 8, 1, 1'b1, 8'd0, 1'b0, 1'b0);
        run_op(3, 0, 0, 0, 0, 0, 0, 1'b0, 8'd0, 1'b0, 1'b0);

        // reset in the middle of a self-copy blit
        X1 = 9'd20; Y1 = 8'd3; X2 = 9'd20; Y2 = 8'd3; op_width = 9'd8; op_height = 8'd4;
        start_blit = 1'b1;
        @(negedge clk);
        start_blit = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("blit_we_before_rst", fb_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_fb_we", fb_we, 0);
        check_eq("arst_status", status, 0);
        check_eq("arst_ready", ram_byte_ready, 0);
        check_eq("arst_ram_byte", ram_byte, 0);
        check_eq("arst_fb_addr", fb_addr, 0);
        check_eq("arst_fb_wdata", fb_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_ptr = 0;
        run_op(2, 0, 0, 0, 0, 0, 0, 1'b0, 8'($urandom), 1'b0, 1'b0);
        mem_check("mem_after_reset");

        // pointer wrap at FB_WIDTH*FB_HEIGHT
        while (model_ptr != 0) run_op(2, 0, 0, 0, 0, 0, 0, 1'b0, 8'($urandom), 1'b0, 1'b0);
        run_op(2, 0, 0, 0, 0, 0, 0, 1'b0, 8'h3C, 1'b0, 1'b0);
        check_eq("wrap_addr", (wr_q.size() > 0) ? wr_q[0] : 32'hFFFFFFFF, 0);
        mem_check("mem_wrap");

        // right-edge fill (clipped only with BLIT_CLIP_EN)
        run_op(0, 318, 10, 0, 0, 4, 2, 1'b1, 8'd0, 1'b0, 1'b0);
        mem_check("mem_edge");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
